// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//
// Turns the debounced button level coming out of the debouncer into
// single-cycle event pulses for the front-panel / control logic:
// press, release, long-press and (optionally) auto-repeat.
//
// Parameters
//   CW            width of the threshold inputs and internal counters
//
// Ports
//   clk           system clock, everything updates on its rising edge
//   rst           synchronous, active-high reset
//   clean         debounced button level, 1 = pressed
//   long_width    cycles from press to the long-press event (0 = no long/repeat)
//   repeat_width  cycles between repeat pulses after long (0 = no repeat)
//   press         one-cycle pulse on press
//   rel           one-cycle pulse on release ("release" is a reserved word
//                 in SystemVerilog, hence the shorter name)
//   long          one-cycle pulse when the hold reaches long_width
//   rpt           one-cycle auto-repeat pulse
//   held          level, high while the button is in the long-press state
//
// Configuration macro
//   BUTTON_EVENT_REPEAT_EN  when defined, the repeat counter and rpt logic
//                           are built. When undefined, rpt is tied low,
//                           repeat_width is ignored, and the LONG state is
//                           kept so held/rel behave the same.
//
// All outputs are registered; there is no combinational path from clean.
// -----------------------------------------------------------------------------
module button_event #(
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clean,
    input  logic [CW-1:0] long_width,
    input  logic [CW-1:0] repeat_width,
    output logic          press,
    output logic          rel,
    output logic          long,
    output logic          rpt,
    output logic          held
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DOWN = 2'd1,
        LONG = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    // Saturating increment: the counters stick at all-ones instead of
    // wrapping, so an unreachable threshold never fires spuriously.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
        logic [CW-1:0] result;
        if (value == CNT_MAX) begin
            result = CNT_MAX;
        end else begin
            result = value + CNT_ONE;
        end
        return result;
    endfunction

    // Registered state
    state_t        state_r;
    logic          c_q;
    logic [CW-1:0] hold_cnt_r;
    logic          press_r;
    logic          rel_r;
    logic          long_r;
    logic          rpt_r;
    logic          held_r;

    // Next-state values
    state_t        state_s;
    logic [CW-1:0] hold_cnt_s;
    logic [CW-1:0] hold_inc_s;
    logic          press_s;
    logic          rel_s;
    logic          long_s;
    logic          rpt_s;
    logic          held_s;
    logic          long_hit_s;

`ifdef BUTTON_EVENT_REPEAT_EN
    logic [CW-1:0] rep_cnt_r;
    logic [CW-1:0] rep_cnt_s;
    logic [CW-1:0] rep_inc_s;
    logic          rep_hit_s;
`else
    // repeat_width has no consumer in this build.
    logic          unused_repeat_s;
    assign unused_repeat_s = ^repeat_width;
`endif

    // Threshold compares use the incremented count, so the event lands on
    // edge k + width where k is the press edge (count is 0 after edge k).
    always_comb begin
        hold_inc_s = sat_inc(hold_cnt_r);
        long_hit_s = (long_width != CNT_ZERO) && (hold_inc_s >= long_width);
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    // Repeat counter increment and threshold compare.
    always_comb begin
        rep_inc_s = sat_inc(rep_cnt_r);
        rep_hit_s = (repeat_width != CNT_ZERO) && (rep_inc_s >= repeat_width);
    end
`endif

    // Next-state and event decode. A falling clean is checked first in the
    // held states so that release wins over a coincident long/rpt.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        press_s    = 1'b0;
        rel_s      = 1'b0;
        long_s     = 1'b0;
        rpt_s      = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
        rep_cnt_s  = rep_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (clean && !c_q) begin
                    press_s    = 1'b1;
                    hold_cnt_s = CNT_ZERO;
                    state_s    = DOWN;
                end else begin
                    state_s    = IDLE;
                end
            end
            DOWN: begin
                if (!clean) begin
                    rel_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    hold_cnt_s = hold_inc_s;
                    if (long_hit_s) begin
                        long_s    = 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                        rep_cnt_s = CNT_ZERO;
`endif
                        state_s   = LONG;
                    end else begin
                        state_s   = DOWN;
                    end
                end
            end
            LONG: begin
                if (!clean) begin
                    rel_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    hold_cnt_s = hold_inc_s;
                    state_s    = LONG;
`ifdef BUTTON_EVENT_REPEAT_EN
                    if (rep_hit_s) begin
                        rpt_s     = 1'b1;
                        rep_cnt_s = CNT_ZERO;
                    end else begin
                        rep_cnt_s = rep_inc_s;
                    end
`endif
                end
            end
            default: begin
                state_s    = IDLE;
                hold_cnt_s = CNT_ZERO;
`ifdef BUTTON_EVENT_REPEAT_EN
                rep_cnt_s  = CNT_ZERO;
`endif
            end
        endcase
        // held follows the state being entered, so it rises with long and
        // falls with rel.
        held_s = (state_s == LONG);
    end

    // State, input sample and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            c_q        <= 1'b0;
            hold_cnt_r <= CNT_ZERO;
            press_r    <= 1'b0;
            rel_r      <= 1'b0;
            long_r     <= 1'b0;
            rpt_r      <= 1'b0;
            held_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            c_q        <= clean;
            hold_cnt_r <= hold_cnt_s;
            press_r    <= press_s;
            rel_r      <= rel_s;
            long_r     <= long_s;
            rpt_r      <= rpt_s;
            held_r     <= held_s;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    // Repeat counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_r <= CNT_ZERO;
        end else begin
            rep_cnt_r <= rep_cnt_s;
        end
    end
`endif

    assign press = press_r;
    assign rel   = rel_r;
    assign long  = long_r;
    assign rpt   = rpt_r;
    assign held  = held_r;

endmodule
